// File: rtl/gpio_pad_mux_pkg.sv
// gpio_pad_mux_pkg
// Shared definitions for the GPIO pad-function controller: register byte
// offsets, STATUS bit positions, the sequencer state type and the width of
// the turnaround counter.
package gpio_pad_mux_pkg;

  // Register byte offsets; the register port decodes whole words only.
  localparam logic [3:0] RegSelTarget = 4'h0;
  localparam logic [3:0] RegSelActive = 4'h4;
  localparam logic [3:0] RegStatus    = 4'h8;
  localparam logic [3:0] RegLock      = 4'hC;

  // STATUS register bit positions.
  localparam int StatusBusyBit = 0;
  localparam int StatusLockBit = 1;

  // Wide enough for the largest turnaround (15 cycles).
  localparam int TurnCntW = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_DRAIN  = 2'd1,
    SEQ_SWITCH = 2'd2
  } seq_state_e;

  // Clear the byte-lane bits so decode compares against word offsets.
  function automatic logic [3:0] word_align(input logic [3:0] byte_addr);
    return {byte_addr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/gpio_pad_mux_seq.sv
// gpio_pad_mux_seq
// Ownership-change sequencer. An accepted selection write that changes the
// active selection starts a drain: the pads whose owner changes are
// tri-stated for TurnCycles cycles, then one SWITCH cycle tells the register
// file to apply the new selection, after which the drain mask clears.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         accepted, unlocked SEL_TARGET write this cycle
//   target_i        value being written to SEL_TARGET
//   active_i        selection currently applied to the pads
//   drain_mask_o    pads whose output enable must be forced low
//   busy_o          sequencer is not IDLE
//   apply_o         SWITCH cycle: copy SEL_TARGET into SEL_ACTIVE
module gpio_pad_mux_seq
  import gpio_pad_mux_pkg::*;
#(
  parameter int NumPads    = 32,
  parameter int TurnCycles = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [NumPads-1:0] target_i,
  input  logic [NumPads-1:0] active_i,
  output logic [NumPads-1:0] drain_mask_o,
  output logic               busy_o,
  output logic               apply_o
);

  // The counter starts at TurnCycles-1 and the DRAIN state is left when it
  // reads 0, so DRAIN occupies exactly TurnCycles cycles.
  localparam logic [TurnCntW-1:0] CntLoad = TurnCntW'(TurnCycles - 1);

  seq_state_e            state_q, state_d;
  logic [TurnCntW-1:0]   cnt_q, cnt_d;
  logic [NumPads-1:0]    mask_q, mask_d;

  always_comb begin
    // NOTE: every signal gets its default before the case so that no path
    // through the logic leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    apply_o = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        // A write equal to the active selection changes nothing on the pads.
        if (start_i && (target_i != active_i)) begin
          state_d = SEQ_DRAIN;
          mask_d  = target_i ^ active_i;
          cnt_d   = CntLoad;
        end
      end
      SEQ_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = SEQ_SWITCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SEQ_SWITCH: begin
        // Mask stays set this cycle: the old owner is still selected but
        // must not drive until the new selection is registered.
        apply_o = 1'b1;
        mask_d  = '0;
        state_d = SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  assign drain_mask_o = mask_q;
  assign busy_o       = (state_q != SEQ_IDLE);

endmodule

// File: rtl/gpio_pad_mux_ctrl.sv
// gpio_pad_mux_ctrl
// Pad-function controller sharing each bidirectional pad between function 0
// (SoC GPIO) and function 1 (alternate/test). A small OBI-style register
// port sets the selection; ownership changes go through a tri-state drain so
// two drivers never overlap on a pad.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cfg_req_i/we_i/addr_i/wdata_i   register request
//   cfg_gnt_o              request accepted this cycle (combinational)
//   cfg_rvalid_o/rdata_o/err_o      one-cycle response, cycle after accept
//   f0_o_i/f0_oe_i, f1_o_i/f1_oe_i  per-function output and enable
//   f0_i_o, f1_i_o         pad input routed to each function (0 if not owner)
//   pad_o_o, pad_oe_o      pad drive and enable (c2p / c2p_en)
//   pad_i_i                pad input (p2c)
//   busy_o                 sequencer not IDLE
module gpio_pad_mux_ctrl
  import gpio_pad_mux_pkg::*;
#(
  parameter int NumPads    = 32,
  parameter int TurnCycles = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_req_i,
  input  logic               cfg_we_i,
  input  logic [3:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic               cfg_gnt_o,
  output logic               cfg_rvalid_o,
  output logic [31:0]        cfg_rdata_o,
  output logic               cfg_err_o,
  input  logic [NumPads-1:0] f0_o_i,
  input  logic [NumPads-1:0] f0_oe_i,
  input  logic [NumPads-1:0] f1_o_i,
  input  logic [NumPads-1:0] f1_oe_i,
  output logic [NumPads-1:0] f0_i_o,
  output logic [NumPads-1:0] f1_i_o,
  output logic [NumPads-1:0] pad_o_o,
  output logic [NumPads-1:0] pad_oe_o,
  input  logic [NumPads-1:0] pad_i_i,
  output logic               busy_o
);

  logic [NumPads-1:0] target_q, target_d;
  logic [NumPads-1:0] active_q;
  logic               lock_q, lock_d;
  logic               rvalid_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [3:0]         reg_addr;
  logic               target_wr_req;
  logic               req_acc, wr_acc, rd_acc;
  logic               sel_start;
  logic [31:0]        rd_word;
  logic               busy;
  logic               apply;
  logic [NumPads-1:0] drain_mask;
  logic               unused_addr_bits;

  assign reg_addr         = word_align(cfg_addr_i);
  assign unused_addr_bits = ^cfg_addr_i[1:0];

  // Only a SEL_TARGET write can be stalled; it waits for the sequencer to
  // return to IDLE. Everything else, including other writes, is granted.
  assign target_wr_req = cfg_req_i && cfg_we_i && (reg_addr == RegSelTarget);
  assign cfg_gnt_o     = !(target_wr_req && busy);
  assign req_acc       = cfg_req_i && cfg_gnt_o;
  assign wr_acc        = req_acc && cfg_we_i;
  assign rd_acc        = req_acc && !cfg_we_i;

  // Register decode: read word, write effects and error flag.
  always_comb begin
    target_d  = target_q;
    lock_d    = lock_q;
    err_d     = 1'b0;
    sel_start = 1'b0;
    rd_word   = '0;

    case (reg_addr)
      RegSelTarget: begin
        rd_word[NumPads-1:0] = target_q;
        if (wr_acc) begin
          if (lock_q) begin
            err_d = 1'b1;
          end else begin
            target_d  = cfg_wdata_i[NumPads-1:0];
            sel_start = 1'b1;
          end
        end
      end
      RegSelActive: begin
        rd_word[NumPads-1:0] = active_q;
        err_d                = wr_acc;
      end
      RegStatus: begin
        rd_word[StatusBusyBit] = busy;
        rd_word[StatusLockBit] = lock_q;
        err_d                  = wr_acc;
      end
      RegLock: begin
        rd_word[0] = lock_q;
        // Lock is sticky: writing 0 leaves it as it is.
        if (wr_acc && cfg_wdata_i[0]) begin
          lock_d = 1'b1;
        end
      end
      default: begin
        err_d = req_acc;
      end
    endcase

    rdata_d = rd_acc ? rd_word : '0;
  end

  gpio_pad_mux_seq #(
    .NumPads   (NumPads),
    .TurnCycles(TurnCycles)
  ) u_seq (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (sel_start),
    .target_i    (cfg_wdata_i[NumPads-1:0]),
    .active_i    (active_q),
    .drain_mask_o(drain_mask),
    .busy_o      (busy),
    .apply_o     (apply)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q <= '0;
      active_q <= '0;
      lock_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      lock_q   <= lock_d;
      rvalid_q <= req_acc;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      if (apply) begin
        active_q <= target_q;
      end
    end
  end

  // Per-pad mux: the selected function drives; drained pads are tri-stated.
  always_comb begin
    for (int k = 0; k < NumPads; k++) begin
      pad_o_o[k]  = active_q[k] ? f1_o_i[k] : f0_o_i[k];
      pad_oe_o[k] = (active_q[k] ? f1_oe_i[k] : f0_oe_i[k]) & ~drain_mask[k];
    end
  end

  assign f1_i_o = pad_i_i & active_q;
  assign f0_i_o = pad_i_i & ~active_q;

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
  assign cfg_err_o    = err_q;
  assign busy_o       = busy;

endmodule

// File: tb/tb_gpio_pad_mux_ctrl.sv
// tb_gpio_pad_mux_ctrl
// Self-checking bench for gpio_pad_mux_ctrl (NumPads = 32, TurnCycles = 4):
// a register-access vector table, hand-written switch/stall/lock/reset
// sequences, and a randomized run against a timeline-based reference model.
module tb_gpio_pad_mux_ctrl;

  localparam int NP = 32;
  localparam int TC = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cfg_req_i = 1'b0;
  logic          cfg_we_i = 1'b0;
  logic [3:0]    cfg_addr_i = '0;
  logic [31:0]   cfg_wdata_i = '0;
  logic          cfg_gnt_o;
  logic          cfg_rvalid_o;
  logic [31:0]   cfg_rdata_o;
  logic          cfg_err_o;
  logic [NP-1:0] f0_o_i = '0, f0_oe_i = '0, f1_o_i = '0, f1_oe_i = '0;
  logic [NP-1:0] f0_i_o, f1_i_o, pad_o_o, pad_oe_o;
  logic [NP-1:0] pad_i_i = '0;
  logic          busy_o;

  gpio_pad_mux_ctrl #(.NumPads(NP), .TurnCycles(TC)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_req_i   (cfg_req_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_wdata_i (cfg_wdata_i),
    .cfg_gnt_o   (cfg_gnt_o),
    .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o (cfg_rdata_o),
    .cfg_err_o   (cfg_err_o),
    .f0_o_i      (f0_o_i),
    .f0_oe_i     (f0_oe_i),
    .f1_o_i      (f1_o_i),
    .f1_oe_i     (f1_oe_i),
    .f0_i_o      (f0_i_o),
    .f1_i_o      (f1_i_o),
    .pad_o_o     (pad_o_o),
    .pad_oe_o    (pad_oe_o),
    .pad_i_i     (pad_i_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Register access vectors, applied from a fresh reset, one after another.
  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          settle;
  } vec_t;

  vec_t vecs[12];

  task automatic do_reset();
    cfg_req_i   = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = '0;
    cfg_wdata_i = '0;
    rst_ni      = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One request: wait (bounded) for grant, then capture the response.
  // Returns at the falling edge of the response cycle.
  task automatic access(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata);
    int n;
    @(posedge clk_i);
    #1;
    cfg_req_i   = 1'b1;
    cfg_we_i    = we;
    cfg_addr_i  = addr;
    cfg_wdata_i = wdata;
    n = 0;
    @(negedge clk_i);
    while (!cfg_gnt_o && n < 40) begin
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      n++;
    end
    if (!cfg_gnt_o) check("gnt_timeout", 32'(cfg_gnt_o), 32'd1);
    @(posedge clk_i);
    #1;
    cfg_req_i = 1'b0;
    @(negedge clk_i);
    check("rsp_rvalid", 32'(cfg_rvalid_o), 32'd1);
    err   = cfg_err_o;
    rdata = cfg_rdata_o;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
    end
  endtask

  // Reference model state for the randomized run.
  logic [NP-1:0] m_target, m_active, m_drain;
  logic          m_lock;
  int            m_busy_end;
  logic          m_rvalid, m_err;
  logic [31:0]   m_rdata;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic          err;
    logic [31:0]   rdata;
    logic [NP-1:0] exp_oe, exp_po;
    logic          exp_busy, exp_gnt, exp_rv;
    int            n;

    vecs[0]  = '{"rd_target_rst", 1'b0, 4'h0, 32'h0,        1'b0, 32'h0, 0};
    vecs[1]  = '{"rd_active_rst", 1'b0, 4'h4, 32'h0,        1'b0, 32'h0, 0};
    vecs[2]  = '{"rd_status_rst", 1'b0, 4'h8, 32'h0,        1'b0, 32'h0, 0};
    vecs[3]  = '{"rd_lock_rst",   1'b0, 4'hC, 32'h0,        1'b0, 32'h0, 0};
    vecs[4]  = '{"wr_active_ro",  1'b1, 4'h4, 32'h1234,     1'b1, 32'h0, 0};
    vecs[5]  = '{"wr_status_ro",  1'b1, 4'h8, 32'h0,        1'b1, 32'h0, 0};
    vecs[6]  = '{"wr_target_nop", 1'b1, 4'h0, 32'h0,        1'b0, 32'h0, 0};
    vecs[7]  = '{"rd_status_nop", 1'b0, 4'h8, 32'h0,        1'b0, 32'h0, 0};
    vecs[8]  = '{"wr_target_5",   1'b1, 4'h0, 32'h5,        1'b0, 32'h0, 7};
    vecs[9]  = '{"rd_active_5",   1'b0, 4'h4, 32'h0,        1'b0, 32'h5, 0};
    vecs[10] = '{"rd_target_b1",  1'b0, 4'h1, 32'h0,        1'b0, 32'h5, 0};
    vecs[11] = '{"rd_active_b3",  1'b0, 4'h7, 32'h0,        1'b0, 32'h5, 0};

    // ---------------- Reset state ----------------
    f0_o_i  = 32'h1357_9BDF;
    f1_o_i  = ~f0_o_i;
    f0_oe_i = 32'hF0F0_3C3C;
    f1_oe_i = 32'h0F0F_C3C3;
    pad_i_i = 32'hDEAD_BEEF;
    rst_ni  = 1'b0;
    #3;
    check("rst_pad_o",  pad_o_o,  f0_o_i);
    check("rst_pad_oe", pad_oe_o, f0_oe_i);
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_gnt",    32'(cfg_gnt_o), 32'd1);
    check("rst_rvalid", 32'(cfg_rvalid_o), 32'd0);
    check("rst_f0_i",   f0_i_o, pad_i_i);
    check("rst_f1_i",   f1_i_o, 32'h0);
    do_reset();
    access(1'b0, 4'h4, 32'h0, err, rdata);
    check("rst_rd_active", rdata, 32'h0);

    // ---------------- Vector table ----------------
    do_reset();
    for (int i = 0; i < 12; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, err, rdata);
      check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      if (!vecs[i].we) check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      idle_cycles(vecs[i].settle);
    end

    // ---------------- Single switch + stalled second write ----------------
    do_reset();
    f0_o_i  = 32'hA5A5_5A5A;
    f1_o_i  = ~f0_o_i;
    f0_oe_i = '1;
    f1_oe_i = '1;
    @(posedge clk_i);
    #1;
    cfg_req_i   = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = 4'h0;
    cfg_wdata_i = 32'h1;
    @(negedge clk_i);
    check("sw_gnt_N", 32'(cfg_gnt_o), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 1 || k == 7) cfg_req_i = 1'b0;
      if (k == 2) begin
        cfg_req_i   = 1'b1;
        cfg_wdata_i = 32'h3;
      end
      @(negedge clk_i);
      exp_busy = (k <= 5) || (k == 7);
      exp_gnt  = !(k >= 2 && k <= 5);
      exp_rv   = (k == 1) || (k == 7);
      exp_oe   = '1;
      if (k <= 5) exp_oe[0] = 1'b0;
      if (k == 7) exp_oe[1] = 1'b0;
      exp_po = f0_o_i;
      if (k >= 6) exp_po[0] = f1_o_i[0];
      check($sformatf("sw_busy_N+%0d", k),   32'(busy_o), 32'(exp_busy));
      check($sformatf("sw_gnt_N+%0d", k),    32'(cfg_gnt_o), 32'(exp_gnt));
      check($sformatf("sw_rvalid_N+%0d", k), 32'(cfg_rvalid_o), 32'(exp_rv));
      check($sformatf("sw_pad_oe_N+%0d", k), pad_oe_o, exp_oe);
      check($sformatf("sw_pad_o_N+%0d", k),  pad_o_o, exp_po);
      if (exp_rv) check($sformatf("sw_err_N+%0d", k), 32'(cfg_err_o), 32'd0);
    end
    n = 0;
    while (busy_o && n < 20) begin
      idle_cycles(1);
      n++;
    end
    check("sw2_busy_done", 32'(busy_o), 32'd0);
    check("sw2_pad_o", pad_o_o, (f0_o_i & ~32'h3) | (f1_o_i & 32'h3));
    access(1'b0, 4'h4, 32'h0, err, rdata);
    check("sw2_rd_active", rdata, 32'h3);

    // ---------------- No-op write (equal to active) ----------------
    access(1'b1, 4'h0, 32'h3, err, rdata);
    check("nop_err", 32'(err), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("nop_busy_%0d", k), 32'(busy_o), 32'd0);
      check($sformatf("nop_oe_%0d", k), pad_oe_o, '1);
      idle_cycles(1);
    end

    // ---------------- Lock ----------------
    do_reset();
    access(1'b1, 4'hC, 32'h1, err, rdata);
    check("lock_wr_err", 32'(err), 32'd0);
    access(1'b0, 4'h8, 32'h0, err, rdata);
    check("lock_status", rdata, 32'h2);
    access(1'b1, 4'h0, 32'hFFFF_FFFF, err, rdata);
    check("lock_sel_err", 32'(err), 32'd1);
    check("lock_no_drain", 32'(busy_o), 32'd0);
    idle_cycles(2);
    check("lock_no_drain2", 32'(busy_o), 32'd0);
    access(1'b0, 4'h0, 32'h0, err, rdata);
    check("lock_target", rdata, 32'h0);
    access(1'b1, 4'h8, 32'h0, err, rdata);
    check("lock_wr_status_err", 32'(err), 32'd1);
    access(1'b1, 4'hC, 32'h0, err, rdata);
    access(1'b0, 4'hC, 32'h0, err, rdata);
    check("lock_sticky", rdata, 32'h1);

    // ---------------- Reset mid-drain ----------------
    do_reset();
    f0_oe_i = 32'hFFFF_0F0F;
    @(posedge clk_i);
    #1;
    cfg_req_i   = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = 4'h0;
    cfg_wdata_i = 32'hFFFF_FFFF;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_i);
      #1;
      cfg_req_i = 1'b0;
      @(negedge clk_i);
    end
    check("mid_drain_oe", pad_oe_o, 32'h0);
    check("mid_drain_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_pad_o",  pad_o_o,  f0_o_i);
    check("mid_rst_pad_oe", pad_oe_o, f0_oe_i);
    check("mid_rst_busy",   32'(busy_o), 32'd0);
    check("mid_rst_f0_i",   f0_i_o, pad_i_i);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    access(1'b0, 4'h0, 32'h0, err, rdata);
    check("mid_rst_target", rdata, 32'h0);
    check("mid_rst_busy_after", 32'(busy_o), 32'd0);

    // ---------------- Randomized run against the model ----------------
    do_reset();
    m_target   = '0;
    m_active   = '0;
    m_drain    = '0;
    m_lock     = 1'b0;
    m_busy_end = -1;
    m_rvalid   = 1'b0;
    m_err      = 1'b0;
    m_rdata    = '0;
    for (int c = 0; c < 500; c++) begin
      logic          busy_now, gnt_now, acc;
      logic [NP-1:0] e_po, e_oe;
      logic [31:0]   rd;
      @(posedge clk_i);
      #1;
      cfg_req_i  = ($urandom_range(0, 2) != 0);
      cfg_we_i   = $urandom_range(0, 1);
      cfg_addr_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) != 0) cfg_addr_i[3:2] = 2'b00;
      cfg_wdata_i = ($urandom_range(0, 2) == 0) ? m_active : $urandom;
      if (cfg_addr_i[3:2] == 2'b11) cfg_wdata_i[0] = ($urandom_range(0, 20) == 0);
      f0_o_i  = $urandom;
      f1_o_i  = $urandom;
      f0_oe_i = $urandom;
      f1_oe_i = $urandom;
      pad_i_i = $urandom;
      @(negedge clk_i);

      busy_now = (m_busy_end >= c);
      gnt_now  = !(cfg_req_i && cfg_we_i && cfg_addr_i[3:2] == 2'b00 && busy_now);
      for (int k = 0; k < NP; k++) begin
        e_po[k] = m_active[k] ? f1_o_i[k] : f0_o_i[k];
        e_oe[k] = (m_active[k] ? f1_oe_i[k] : f0_oe_i[k]) && !(busy_now && m_drain[k]);
      end
      check("rnd_busy",   32'(busy_o), 32'(busy_now));
      check("rnd_gnt",    32'(cfg_gnt_o), 32'(gnt_now));
      check("rnd_pad_o",  pad_o_o, e_po);
      check("rnd_pad_oe", pad_oe_o, e_oe);
      check("rnd_f0_i",   f0_i_o, pad_i_i & ~m_active);
      check("rnd_f1_i",   f1_i_o, pad_i_i & m_active);
      check("rnd_rvalid", 32'(cfg_rvalid_o), 32'(m_rvalid));
      if (m_rvalid) begin
        check("rnd_err", 32'(cfg_err_o), 32'(m_err));
        check("rnd_rdata", cfg_rdata_o, m_rdata);
      end

      // Effect of the coming clock edge.
      acc      = cfg_req_i && gnt_now;
      m_rvalid = acc;
      m_err    = 1'b0;
      m_rdata  = '0;
      case (cfg_addr_i[3:2])
        2'd0: rd = m_target;
        2'd1: rd = m_active;
        2'd2: rd = {30'd0, m_lock, busy_now};
        default: rd = {31'd0, m_lock};
      endcase
      if (acc && !cfg_we_i) m_rdata = rd;
      if (c == m_busy_end) m_active = m_target;
      if (acc && cfg_we_i) begin
        case (cfg_addr_i[3:2])
          2'd0: begin
            if (m_lock) begin
              m_err = 1'b1;
            end else begin
              m_target = cfg_wdata_i;
              if (cfg_wdata_i != m_active) begin
                m_drain    = cfg_wdata_i ^ m_active;
                m_busy_end = c + TC + 1;
              end
            end
          end
          2'd1, 2'd2: m_err = 1'b1;
          default: if (cfg_wdata_i[0]) m_lock = 1'b1;
        endcase
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_pad_mux_ctrl.md
# gpio_pad_mux_ctrl

Pad-function controller between `croc_soc` GPIO signals and the `sg13g2_IOPadInOut30mA` pad ring. It shares each bidirectional pad between two functions: function 0, SoC GPIO, and function 1, an alternate/test function. Selection is set through a small OBI-style register port. Every ownership change is sequenced through a drain phase. During drain, the affected pads are tri-stated for a fixed turnaround so two drivers never overlap.

## Interface
Parameters:
- `NumPads`, 32, number of shared pads (1..32)
- `TurnCycles`, 4, tri-state turnaround length in cycles (1..15)

Ports:
- `clk_i` in 1: block clock
- `rst_ni` in 1: reset; **one clock; reset is asynchronous and active-low**
- `cfg_req_i` in 1: register request
- `cfg_we_i` in 1: 1 = write
- `cfg_addr_i` in 4: byte address; bits [1:0] ignored
- `cfg_wdata_i` in 32: write data
- `cfg_gnt_o` out 1: request accepted this cycle
- `cfg_rvalid_o` out 1: response valid
- `cfg_rdata_o` out 32: read data
- `cfg_err_o` out 1: response error, qualified by `cfg_rvalid_o`
- `f0_o_i`, `f0_oe_i` in NumPads: function 0 output and output enable
- `f1_o_i`, `f1_oe_i` in NumPads: function 1 output and output enable
- `f0_i_o`, `f1_i_o` out NumPads: pad input routed to each function
- `pad_o_o`, `pad_oe_o` out NumPads: drive to the pad `c2p` / `c2p_en`
- `pad_i_i` in NumPads: pad `p2c`
- `busy_o` out 1: sequencer not IDLE

## Operation
- **Registers** (word offsets):
  - 0x0 SEL_TARGET, RW: bit k = 1 selects function 1 for pad k. Bits ≥ NumPads read 0.
  - 0x4 SEL_ACTIVE, RO: the selection currently applied.
  - 0x8 STATUS, RO: bit0 = busy, bit1 = lock.
  - 0xC LOCK: writing bit0 = 1 sets lock. Lock is sticky until reset.
- **Grant rule:**
  - Reads are always granted.
  - A write to SEL_TARGET while busy has `cfg_gnt_o` = 0 and stalls until IDLE.
  - All other writes are granted immediately.
- **Error responses:**
  - A write to a RO register or an unmapped address is ignored and returns `cfg_err_o` = 1.
  - A write to SEL_TARGET while lock = 1 is ignored and returns err = 1.
  - An unmapped read returns 0 with err = 1.
- **Sequencer FSM:**
  - IDLE → DRAIN on an accepted SEL_TARGET write whose value differs from SEL_ACTIVE. The drain mask becomes target XOR active, and the counter loads TurnCycles−1.
  - An accepted write equal to SEL_ACTIVE stays in IDLE.
  - DRAIN decrements the counter each cycle. At 0 it goes to SWITCH.
  - SWITCH: SEL_ACTIVE ← SEL_TARGET, drain mask clears, next state is IDLE.
- **Datapath** (combinational from registered state):
  - `pad_o_o[k]` = SEL_ACTIVE[k] ? f1_o : f0_o.
  - `pad_oe_o[k]` = selected oe AND NOT drain_mask[k].
  - The owning function receives `pad_i_i[k]`; the non-owner receives 0.
  - Pads not in the drain mask are unaffected during DRAIN.

## Timing
- **Reset values:**
  - `cfg_gnt_o` = 1 (combinational)
  - `cfg_rvalid_o`, `cfg_rdata_o`, `cfg_err_o` = 0
  - SEL_TARGET, SEL_ACTIVE, lock and drain mask = 0
  - FSM in IDLE; `busy_o` = 0
  - Pads therefore follow function 0.
- **Response latency:** a request accepted in cycle N has `cfg_rvalid_o`, `cfg_rdata_o` and `cfg_err_o` valid in N+1 for exactly one cycle.
- **Switch timeline:** for a SEL write accepted in N:
  - N+1: affected `pad_oe_o` forced to 0 and `busy_o` = 1.
  - The drain lasts N+1..N+TurnCycles.
  - SWITCH is at N+TurnCycles+1, when the pad still shows the old owner with OE forced to 0.
  - N+TurnCycles+2: new owner drives, `busy_o` = 0, and a stalled write may be granted.
- **Read-back:** a SEL_ACTIVE read returns the value registered at the accept edge.
- **Simultaneous events:** a stalled SEL write and the return to IDLE do not race; the grant asserts in the first IDLE cycle.
- **Reset mid-DRAIN:** all state clears immediately and asynchronously; all pads revert to function 0.

## Structure
- Package `gpio_pad_mux_pkg` holds:
  - register offset localparams;
  - the `seq_state_e` enum (IDLE, DRAIN, SWITCH);
  - the STATUS bit positions.
- Sub-module `gpio_pad_mux_seq` holds the FSM, turnaround counter and drain-mask register.
- The top level holds the register file, OBI response logic and per-pad muxes.

## Test plan
All scenarios use NumPads = 32 and TurnCycles = 4.
- **Reset:** assert reset → `pad_o_o` equals `f0_o_i` exactly, `pad_oe_o` equals `f0_oe_i`, `busy_o` = 0, and SEL_ACTIVE reads 0x0.
- **Single switch:** write SEL_TARGET = 0x0000_0001 at N → `pad_oe_o[0]` = 0 for N+1..N+5, pad 0 carries f1 from N+6, `busy_o` is high for N+1..N+5, and other pads are undisturbed.
- **Stall:** a second SEL write issued at N+2 → `cfg_gnt_o` = 0 until N+6, granted at N+6, and its own drain starts at N+7.
- **Lock:** write LOCK = 1, then SEL_TARGET = 0xFFFF_FFFF → `cfg_err_o` = 1, SEL_TARGET still 0, no drain. A write of 0x0 to STATUS → err = 1.
- **Reset mid-drain:** deassert `rst_ni` at N+3 of a drain → all pads revert to function 0 asynchronously, and after release SEL_TARGET reads 0 and `busy_o` = 0.
- **No-op write:** write SEL_TARGET equal to SEL_ACTIVE → no DRAIN, `busy_o` stays 0, response is err = 0.
